rf_dump: RTL and testbench

RF_DUMP -- requirements
Module: rf_dump

---
 rtl/rf_dump_pkg.sv | 14 +
 rtl/rf_dump.sv | 127 ++++++++++++
 tb/tb_rf_dump.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_dump_pkg.sv
// Shared register-file constants and the dump FSM state type.
package rf_dump_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/rf_dump.sv
// rf_dump: walks register-file addresses 0..NREG-1 through the debug read
// port and streams each captured value out over a valid/ready channel.
//
// Output handshake: a word transfers on a rising clk edge where out_valid and
// out_ready are both high. Once out_valid rises, out_valid, out_data and
// out_addr stay stable until that transfer; only abort or rst may withdraw
// the word early. The producer never waits on out_ready before asserting
// out_valid.
module rf_dump
    import rf_dump_pkg::*;
#(
    parameter int NREG = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic [RF_ADDR_W-1:0] rs_debug,
    input  logic [RF_DATA_W-1:0] debug_rf,
    input  logic                 rf_we,
    input  logic [RF_ADDR_W-1:0] rf_rd,
    input  logic [RF_DATA_W-1:0] rf_wdata,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [RF_ADDR_W-1:0] out_addr,
    output logic [RF_DATA_W-1:0] out_data,
    output logic                 out_last,
    output logic [1:0]           dbg_state
);

    localparam logic [RF_ADDR_W-1:0] LAST_ADDR = RF_ADDR_W'(NREG - 1);

    state_e                 state_q, state_d;
    logic [RF_ADDR_W-1:0]   addr_q, addr_d;
    logic                   out_valid_q, out_valid_d;
    logic [RF_ADDR_W-1:0]   out_addr_q, out_addr_d;
    logic [RF_DATA_W-1:0]   out_data_q, out_data_d;

    // A write landing on the address being read in the same cycle would be
    // missed by the asynchronous read port, so forward it. Register 0 is
    // hardwired to zero in the register file and is never forwarded.
    logic                   bypass;
    assign bypass = rf_we && (rf_rd == addr_q) && (rf_rd != '0);

    // State and datapath registers; rst clears everything from any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
        end
    end

    // Next-state logic; abort beats start in IDLE and beats a handshake in SEND.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    addr_d  = '0;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (abort) begin
                    state_d     = ST_IDLE;
                    addr_d      = '0;
                    out_valid_d = 1'b0;
                end else begin
                    out_data_d  = bypass ? rf_wdata : debug_rf;
                    out_addr_d  = addr_q;
                    out_valid_d = 1'b1;
                    state_d     = ST_SEND;
                end
            end
            ST_SEND: begin
                if (abort) begin
                    state_d     = ST_IDLE;
                    addr_d      = '0;
                    out_valid_d = 1'b0;
                end else if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    if (addr_q == LAST_ADDR) begin
                        state_d = ST_DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = ST_READ;
                    end
                end
            end
            ST_DONE: begin
                // Leaves after one cycle whether or not abort is high.
                state_d = ST_IDLE;
                addr_d  = '0;
            end
            default: begin
                state_d     = ST_IDLE;
                addr_d      = '0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign rs_debug  = addr_q;
    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;
    assign out_last  = out_valid_q && (out_addr_q == LAST_ADDR);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_rf_dump.sv
// Bench for rf_dump: scenario table plus hand-written reset/abort/NREG=4 cases.
module tb_rf_dump;
    import rf_dump_pkg::*;

    localparam int N  = 32;
    localparam int N4 = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        start, abort, out_ready, rf_we, rf_load;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic        busy, done, out_valid, out_last;
    logic [4:0]  rs_debug, out_addr;
    logic [31:0] out_data, debug_rf;
    logic [1:0]  dbg_state;

    logic        start4, abort4;
    logic        busy4, done4, out_valid4, out_last4;
    logic [4:0]  rs_debug4, out_addr4;
    logic [31:0] out_data4, debug_rf4;
    logic [1:0]  dbg_state4;

    rf_dump #(.NREG(N)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(busy), .done(done), .rs_debug(rs_debug), .debug_rf(debug_rf),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_data(out_data), .out_last(out_last), .dbg_state(dbg_state)
    );

    rf_dump #(.NREG(N4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .abort(abort4),
        .busy(busy4), .done(done4), .rs_debug(rs_debug4), .debug_rf(debug_rf4),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .out_valid(out_valid4), .out_ready(out_ready), .out_addr(out_addr4),
        .out_data(out_data4), .out_last(out_last4), .dbg_state(dbg_state4)
    );

    // ---------------- register file model ----------------
    // Register 0 reads as zero and ignores writes.
    logic [31:0] rf_mem [32];
    always @(posedge clk) begin
        if (rf_load) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= 32'(32'h1111 * i);
        end else if (rf_we && rf_rd != 5'd0) begin
            rf_mem[rf_rd] <= rf_wdata;
        end
    end
    assign debug_rf  = rf_mem[rs_debug];
    assign debug_rf4 = rf_mem[rs_debug4];

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [4:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_valid"},     32'(out_valid), 32'd0);
        check({tag, "_done"},      32'(done),      32'd0);
        check({tag, "_last"},      32'(out_last),  32'd0);
        check({tag, "_rs_debug"},  32'(rs_debug),  32'd0);
        check({tag, "_dbg_state"}, 32'(dbg_state), 32'd0);
    endtask

    // ---------------- scenario table ----------------
    // ready_mode: 0 = always ready, 1 = ready one cycle in three, 2 = random
    //             ready plus random register-file writes.
    // wr_at:      word index whose capture cycle carries a directed write (-1 none).
    // abort_at:   word index whose offer gets abort with out_ready high (-1 none).
    // exp_cycles: cycle (counted from the edge before start) at which busy
    //             is low again; 0 means not checked.
    typedef struct {
        int          ready_mode;
        int          wr_at;
        logic [4:0]  wr_rd;
        logic [31:0] wr_data;
        int          abort_at;
        int          exp_words;
        int          exp_done;
        int          exp_cycles;
    } vec_t;

    task automatic run_vec(input int vi, input vec_t v);
        int n_acc = 0, n_done = 0, cyc = 1, first_v = -1, abort_cyc = -1;
        bit prev_valid = 0, prev_ready = 0, prev_abort = 0, aborted = 0, ended = 0;
        logic [31:0] held_data = '0;
        logic [4:0]  held_addr = '0;
        logic [4:0]  exp_rs;

        exp_q.delete();
        for (int a = 0; a < N; a++) exp_q.push_back(5'(a));
        rf_load = 1'b1;
        @(posedge clk); #1;
        rf_load = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;

        while (cyc < 500) begin
            if (!busy) begin
                ended = 1;
                break;
            end
            exp_rs = (n_acc < N) ? 5'(n_acc) : 5'(N - 1);
            check("rs_debug", 32'(rs_debug), 32'(exp_rs));
            if (prev_valid && !prev_ready && !prev_abort)
                check("valid_held", 32'(out_valid), 32'd1);
            if (out_valid && !prev_valid) begin
                if (first_v < 0) first_v = cyc;
                if (exp_q.size() == 0) begin
                    check("extra_word", 32'(out_valid), 32'd0);
                end else begin
                    check("word_addr", 32'(out_addr), 32'(exp_q[0]));
                    check("word_data", out_data, rf_mem[exp_q[0]]);
                end
            end
            if (out_valid && prev_valid) begin
                check("hold_data", out_data, held_data);
                check("hold_addr", 32'(out_addr), 32'(held_addr));
            end
            check("out_last", 32'(out_last), 32'(out_valid && exp_q.size() == 1));
            if (done) n_done++;

            // inputs for this cycle
            rf_we = 1'b0; rf_rd = '0; rf_wdata = '0; abort = 1'b0;
            start = (cyc == 15) && !aborted;
            case (v.ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (v.ready_mode == 2 && $urandom_range(0, 3) == 0) begin
                rf_we    = 1'b1;
                rf_rd    = 5'($urandom_range(0, 31));
                rf_wdata = $urandom;
            end
            if (v.wr_at >= 0 && !out_valid && !done && n_acc == v.wr_at) begin
                rf_we    = 1'b1;
                rf_rd    = v.wr_rd;
                rf_wdata = v.wr_data;
            end
            if (v.abort_at >= 0 && out_valid && n_acc == v.abort_at) begin
                abort     = 1'b1;
                out_ready = 1'b1;
                aborted   = 1;
                abort_cyc = cyc;
            end
            if (out_valid && out_ready && !abort && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                n_acc++;
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_abort = abort;
            held_data  = out_data;
            held_addr  = out_addr;
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b0; rf_we = 1'b0; abort = 1'b0; start = 1'b0;

        check($sformatf("v%0d_finished", vi), 32'(ended), 32'd1);
        check($sformatf("v%0d_words", vi), 32'(n_acc), 32'(v.exp_words));
        check($sformatf("v%0d_done_pulses", vi), 32'(n_done), 32'(v.exp_done));
        check_idle_outputs($sformatf("v%0d_end", vi));
        if (v.exp_cycles > 0) begin
            check($sformatf("v%0d_first_valid_cyc", vi), 32'(first_v), 32'd2);
            check($sformatf("v%0d_idle_cyc", vi), 32'(cyc), 32'(v.exp_cycles));
        end
        if (aborted)
            check($sformatf("v%0d_abort_latency", vi), 32'(cyc), 32'(abort_cyc + 1));
    endtask

    // ---------------- main ----------------
    initial begin
        vec_t vecs[7];
        int k, n, nd, cyc;

        vecs[0] = '{0, -1, 5'd0, 32'h0,    -1, 32, 1, 2*N+2};
        vecs[1] = '{1, -1, 5'd0, 32'h0,    -1, 32, 1, 0};
        vecs[2] = '{0,  5, 5'd5, 32'h2222, -1, 32, 1, 2*N+2};
        vecs[3] = '{0,  0, 5'd0, 32'h2222, -1, 32, 1, 2*N+2};
        vecs[4] = '{0, -1, 5'd0, 32'h0,    10, 10, 0, 0};
        vecs[5] = '{2, -1, 5'd0, 32'h0,    -1, 32, 1, 0};
        vecs[6] = '{2, -1, 5'd0, 32'h0,    20, 20, 0, 0};

        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        rf_we = 1'b0; rf_rd = '0; rf_wdata = '0; rf_load = 1'b1;
        start4 = 1'b0; abort4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rf_load = 1'b0;
        check_idle_outputs("reset");
        check("reset_out_data", out_data, 32'd0);
        check("reset_out_addr", 32'(out_addr), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // start and abort together in IDLE: abort wins
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check_idle_outputs("start_abort");
        // abort alone in IDLE does nothing
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check_idle_outputs("idle_abort");

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // reset in the middle of a dump, with start also high
        out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (!(out_valid && out_addr == 5'd17) && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check("reach_addr17", 32'(out_addr), 32'd17);
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        check_idle_outputs("midreset");
        check("midreset_out_data", out_data, 32'd0);
        check("midreset_out_addr", 32'(out_addr), 32'd0);
        @(posedge clk); #1;
        check_idle_outputs("midreset_after");

        // NREG = 4 instance
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        n = 0; nd = 0; cyc = 1;
        while (cyc < 100) begin
            if (!busy4) break;
            if (out_valid4) begin
                check("n4_addr", 32'(out_addr4), 32'(n));
                check("n4_data", out_data4, rf_mem[n % 32]);
                check("n4_last", 32'(out_last4), 32'(n == N4 - 1));
                n++;
            end
            if (done4) nd++;
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b0;
        check("n4_words", 32'(n), 32'(N4));
        check("n4_done_pulses", 32'(nd), 32'd1);
        check("n4_idle_cyc", 32'(cyc), 32'(2*N4+2));
        check("n4_state_idle", 32'(dbg_state4), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
